// File: rtl/sched_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared types and constants for the issue scheduler.
//   uop_t          : decoded micro-op fields carried through the queue
//   TAG_W_DEFAULT  : default physical/ROB tag width
//   ALU_*          : ALU operation encodings
//   uop_is_mem     : uop touches memory (load or store)
//   uop_need_rs2   : uop consumes its second register operand
// -----------------------------------------------------------------------------
package sched_pkg;

  localparam int TAG_W_DEFAULT = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SRA = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] imm;
  } uop_t;

  function automatic logic uop_is_mem(input uop_t u);
    return u.mem_read | u.mem_write;
  endfunction

  // Stores always need rs2 (store data) even though alu_src selects the immediate.
  function automatic logic uop_need_rs2(input uop_t u);
    return ~u.alu_src | u.mem_write;
  endfunction

endpackage

// File: rtl/rs_entry.sv
// -----------------------------------------------------------------------------
// rs_entry
// One reservation-queue slot: uop storage, operand ready bits, CDB wakeup
// compare and the slot's issue eligibility.
// Optional feature macro: ISSUE_BYPASS_EN (a CDB match in the current cycle
// counts as ready for eligibility).
// Ports:
//   clk, rst_n, flush       clock, async active-low reset, sync clear of valid
//   wr_en, wr_*             load the slot (new uop or shift from the slot above)
//   cdb_valid, cdb_tag      result broadcast used for wakeup
//   older_mem               some older valid slot holds a load/store
//   valid, uop, *_tag       slot contents
//   rs1_rdy_nxt/rs2_rdy_nxt ready bits including this cycle's wakeup
//   need_rs2, is_mem        decoded operand/memory attributes
//   eligible                slot may be selected for issue this cycle
// -----------------------------------------------------------------------------
module rs_entry
  import sched_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic             wr_valid,
  input  uop_t             wr_uop,
  input  logic [TAG_W-1:0] wr_rs1_tag,
  input  logic             wr_rs1_rdy,
  input  logic [TAG_W-1:0] wr_rs2_tag,
  input  logic             wr_rs2_rdy,
  input  logic             wr_need_rs2,
  input  logic [TAG_W-1:0] wr_rd_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             older_mem,
  output logic             valid,
  output uop_t             uop,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs1_rdy_nxt,
  output logic [TAG_W-1:0] rs2_tag,
  output logic             rs2_rdy_nxt,
  output logic             need_rs2,
  output logic [TAG_W-1:0] rd_tag,
  output logic             is_mem,
  output logic             eligible
);

  logic             valid_r;
  uop_t             uop_r;
  logic [TAG_W-1:0] rs1_tag_r;
  logic             rs1_rdy_r;
  logic [TAG_W-1:0] rs2_tag_r;
  logic             rs2_rdy_r;
  logic             need_rs2_r;
  logic [TAG_W-1:0] rd_tag_r;
  logic             op1_ok_s;
  logic             op2_ok_s;

  assign rs1_rdy_nxt = rs1_rdy_r | (cdb_valid & (cdb_tag == rs1_tag_r));
  assign rs2_rdy_nxt = rs2_rdy_r | (cdb_valid & (cdb_tag == rs2_tag_r));

`ifdef ISSUE_BYPASS_EN
  assign op1_ok_s = rs1_rdy_nxt;
  assign op2_ok_s = rs2_rdy_nxt | ~need_rs2_r;
`else
  assign op1_ok_s = rs1_rdy_r;
  assign op2_ok_s = rs2_rdy_r | ~need_rs2_r;
`endif

  assign is_mem   = uop_is_mem(uop_r);
  assign eligible = valid_r & op1_ok_s & op2_ok_s & (~is_mem | ~older_mem);

  assign valid    = valid_r;
  assign uop      = uop_r;
  assign rs1_tag  = rs1_tag_r;
  assign rs2_tag  = rs2_tag_r;
  assign need_rs2 = need_rs2_r;
  assign rd_tag   = rd_tag_r;

  // Slot state: load on write, otherwise accumulate CDB wakeups; flush kills the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      uop_r      <= '0;
      rs1_tag_r  <= '0;
      rs1_rdy_r  <= 1'b0;
      rs2_tag_r  <= '0;
      rs2_rdy_r  <= 1'b0;
      need_rs2_r <= 1'b0;
      rd_tag_r   <= '0;
    end else if (flush) begin
      valid_r    <= 1'b0;
    end else if (wr_en) begin
      valid_r    <= wr_valid;
      uop_r      <= wr_uop;
      rs1_tag_r  <= wr_rs1_tag;
      rs1_rdy_r  <= wr_rs1_rdy;
      rs2_tag_r  <= wr_rs2_tag;
      rs2_rdy_r  <= wr_rs2_rdy;
      need_rs2_r <= wr_need_rs2;
      rd_tag_r   <= wr_rd_tag;
    end else begin
      rs1_rdy_r  <= rs1_rdy_nxt;
      rs2_rdy_r  <= rs2_rdy_nxt;
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
// Collapsing reservation queue between decode and execute. Entry 0 is the
// oldest; the oldest eligible uop issues, one per cycle. Loads/stores stay in
// program order relative to each other.
// Optional feature macro: ISSUE_BYPASS_EN (CDB wakeup usable for issue in the
// same cycle; without it a woken operand is usable from the next cycle).
// Ports:
//   clk, rst_n, flush                       clock, async active-low reset, mispredict clear
//   in_valid/in_ready, in_uop, in_rs*_tag,
//   in_rs*_rdy, in_rd_tag                   enqueue side
//   cdb_valid, cdb_tag                      result broadcast
//   iss_valid/iss_ready, iss_uop,
//   iss_rs1_tag, iss_rs2_tag, iss_rd_tag,
//   iss_lsu                                 issue side
//   count                                   number of valid entries
// -----------------------------------------------------------------------------
module issue_scheduler
  import sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEFAULT,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  uop_t             in_uop,
  input  logic [TAG_W-1:0] in_rs1_tag,
  input  logic             in_rs1_rdy,
  input  logic [TAG_W-1:0] in_rs2_tag,
  input  logic             in_rs2_rdy,
  input  logic [TAG_W-1:0] in_rd_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             iss_valid,
  input  logic             iss_ready,
  output uop_t             iss_uop,
  output logic [TAG_W-1:0] iss_rs1_tag,
  output logic [TAG_W-1:0] iss_rs2_tag,
  output logic [TAG_W-1:0] iss_rd_tag,
  output logic             iss_lsu,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [CW-1:0]    count_r;
  logic             enq_s;
  logic             fire_s;
  logic [CW-1:0]    new_idx_s;
  logic [IW-1:0]    sel_s;
  logic             mem_seen_s;
  logic             new_rs1_rdy_s;
  logic             new_rs2_rdy_s;

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_elig;
  logic [DEPTH-1:0] e_mem;
  logic [DEPTH-1:0] e_older;
  uop_t             e_uop       [DEPTH];
  logic [TAG_W-1:0] e_rs1_tag   [DEPTH];
  logic             e_rs1_nxt   [DEPTH];
  logic [TAG_W-1:0] e_rs2_tag   [DEPTH];
  logic             e_rs2_nxt   [DEPTH];
  logic             e_need_rs2  [DEPTH];
  logic [TAG_W-1:0] e_rd_tag    [DEPTH];

  // Capacity depends on count only, so a full queue stalls even while issuing.
  assign in_ready  = (count_r < CNT_FULL);
  assign enq_s     = in_valid & in_ready;
  assign fire_s    = iss_valid & iss_ready;
  assign count     = count_r;
  // With a same-cycle issue the queue shifts first, so the new uop lands one lower.
  assign new_idx_s = fire_s ? (count_r - CNT_ONE) : count_r;

  assign new_rs1_rdy_s = in_rs1_rdy | (cdb_valid & (cdb_tag == in_rs1_tag));
  assign new_rs2_rdy_s = in_rs2_rdy | (cdb_valid & (cdb_tag == in_rs2_tag));

  // Prefix OR: does any older valid slot hold a load/store.
  always_comb begin
    mem_seen_s = 1'b0;
    e_older    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e_older[i] = mem_seen_s;
      mem_seen_s = mem_seen_s | (e_valid[i] & e_mem[i]);
    end
  end

  // Lowest-index eligible slot wins (scan from the top so the lowest overwrites).
  always_comb begin
    sel_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (e_elig[i]) begin
        sel_s = IW'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  assign iss_valid = |e_elig;

  // Issue-side mux; fields read zero when nothing is eligible.
  always_comb begin
    iss_uop     = '0;
    iss_rs1_tag = '0;
    iss_rs2_tag = '0;
    iss_rd_tag  = '0;
    if (iss_valid) begin
      iss_uop     = e_uop[sel_s];
      iss_rs1_tag = e_rs1_tag[sel_s];
      iss_rs2_tag = e_rs2_tag[sel_s];
      iss_rd_tag  = e_rd_tag[sel_s];
    end else begin
      iss_uop     = '0;
    end
  end

  assign iss_lsu = uop_is_mem(iss_uop);

  // Occupancy counter; flush discards any enqueue in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else begin
      case ({enq_s, fire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [CW-1:0] IDX = CW'(i);

    logic             load_new;
    logic             shift_en;
    logic             up_valid;
    uop_t             up_uop;
    logic [TAG_W-1:0] up_rs1_tag;
    logic             up_rs1_rdy;
    logic [TAG_W-1:0] up_rs2_tag;
    logic             up_rs2_rdy;
    logic             up_need_rs2;
    logic [TAG_W-1:0] up_rd_tag;
    logic             w_valid;
    uop_t             w_uop;
    logic [TAG_W-1:0] w_rs1_tag;
    logic             w_rs1_rdy;
    logic [TAG_W-1:0] w_rs2_tag;
    logic             w_rs2_rdy;
    logic             w_need_rs2;
    logic [TAG_W-1:0] w_rd_tag;

    assign load_new = enq_s & (new_idx_s == IDX);
    assign shift_en = fire_s & (IDX >= CW'(sel_s));

    if (i < DEPTH - 1) begin : g_up
      // Shifted ready bits include this cycle's wakeup so no broadcast is lost.
      assign up_valid    = e_valid[i+1];
      assign up_uop      = e_uop[i+1];
      assign up_rs1_tag  = e_rs1_tag[i+1];
      assign up_rs1_rdy  = e_rs1_nxt[i+1];
      assign up_rs2_tag  = e_rs2_tag[i+1];
      assign up_rs2_rdy  = e_rs2_nxt[i+1];
      assign up_need_rs2 = e_need_rs2[i+1];
      assign up_rd_tag   = e_rd_tag[i+1];
    end else begin : g_top
      assign up_valid    = 1'b0;
      assign up_uop      = '0;
      assign up_rs1_tag  = '0;
      assign up_rs1_rdy  = 1'b0;
      assign up_rs2_tag  = '0;
      assign up_rs2_rdy  = 1'b0;
      assign up_need_rs2 = 1'b0;
      assign up_rd_tag   = '0;
    end

    // Write data: a new uop takes priority over the shifted neighbour.
    always_comb begin
      w_valid    = up_valid;
      w_uop      = up_uop;
      w_rs1_tag  = up_rs1_tag;
      w_rs1_rdy  = up_rs1_rdy;
      w_rs2_tag  = up_rs2_tag;
      w_rs2_rdy  = up_rs2_rdy;
      w_need_rs2 = up_need_rs2;
      w_rd_tag   = up_rd_tag;
      if (load_new) begin
        w_valid    = 1'b1;
        w_uop      = in_uop;
        w_rs1_tag  = in_rs1_tag;
        w_rs1_rdy  = new_rs1_rdy_s;
        w_rs2_tag  = in_rs2_tag;
        w_rs2_rdy  = new_rs2_rdy_s;
        w_need_rs2 = uop_need_rs2(in_uop);
        w_rd_tag   = in_rd_tag;
      end else begin
        w_valid    = up_valid;
      end
    end

    rs_entry #(.TAG_W(TAG_W)) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .wr_en       (load_new | shift_en),
      .wr_valid    (w_valid),
      .wr_uop      (w_uop),
      .wr_rs1_tag  (w_rs1_tag),
      .wr_rs1_rdy  (w_rs1_rdy),
      .wr_rs2_tag  (w_rs2_tag),
      .wr_rs2_rdy  (w_rs2_rdy),
      .wr_need_rs2 (w_need_rs2),
      .wr_rd_tag   (w_rd_tag),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .older_mem   (e_older[i]),
      .valid       (e_valid[i]),
      .uop         (e_uop[i]),
      .rs1_tag     (e_rs1_tag[i]),
      .rs1_rdy_nxt (e_rs1_nxt[i]),
      .rs2_tag     (e_rs2_tag[i]),
      .rs2_rdy_nxt (e_rs2_nxt[i]),
      .need_rs2    (e_need_rs2[i]),
      .rd_tag      (e_rd_tag[i]),
      .is_mem      (e_mem[i]),
      .eligible    (e_elig[i])
    );
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
// Directed bench for issue_scheduler (DEPTH=8, TAG_W=4). Expected issue order
// is queued as {alu_op, rd_tag} when stimulus is driven and popped on every
// issue handshake. Honours ISSUE_BYPASS_EN where same-cycle wakeup changes
// the cycle in which an issue happens.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;
  import sched_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  uop_t       in_uop;
  logic [3:0] in_rs1_tag;
  logic       in_rs1_rdy;
  logic [3:0] in_rs2_tag;
  logic       in_rs2_rdy;
  logic [3:0] in_rd_tag;
  logic       cdb_valid;
  logic [3:0] cdb_tag;
  logic       iss_valid;
  logic       iss_ready;
  uop_t       iss_uop;
  logic [3:0] iss_rs1_tag;
  logic [3:0] iss_rs2_tag;
  logic [3:0] iss_rd_tag;
  logic       iss_lsu;
  logic [3:0] count;

  int compared;
  int mismatched;
  logic [6:0] sb[$];

  issue_scheduler #(.DEPTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
    .in_rs1_tag(in_rs1_tag), .in_rs1_rdy(in_rs1_rdy),
    .in_rs2_tag(in_rs2_tag), .in_rs2_rdy(in_rs2_rdy), .in_rd_tag(in_rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_uop(iss_uop),
    .iss_rs1_tag(iss_rs1_tag), .iss_rs2_tag(iss_rs2_tag), .iss_rd_tag(iss_rd_tag),
    .iss_lsu(iss_lsu), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic src, input logic mr, input logic mw,
                       input logic [3:0] t1, input logic r1, input logic [3:0] t2,
                       input logic r2, input logic [3:0] rd);
    in_valid          = 1'b1;
    in_uop            = '0;
    in_uop.alu_op     = op;
    in_uop.alu_src    = src;
    in_uop.mem_read   = mr;
    in_uop.mem_write  = mw;
    in_uop.mem_to_reg = mr;
    in_uop.reg_write  = ~mw;
    in_uop.imm        = {28'h0, rd};
    in_rs1_tag        = t1;
    in_rs1_rdy        = r1;
    in_rs2_tag        = t2;
    in_rs2_rdy        = r2;
    in_rd_tag         = rd;
  endtask

  // One clock: score any issue handshake, then clear pulse-style inputs.
  task automatic tick();
    logic [6:0] exp;
    #1;
    if (iss_valid && iss_ready) begin
      check("issue_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("issue_order", 64'({iss_uop.alu_op, iss_rd_tag}), 64'(exp));
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int k = 0; k < max_cycles && sb.size() != 0; k++) tick();
    check("drain_done", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_uop = '0;
    in_rs1_tag = 4'h0; in_rs1_rdy = 1'b0; in_rs2_tag = 4'h0; in_rs2_rdy = 1'b0;
    in_rd_tag = 4'h0; cdb_valid = 1'b0; cdb_tag = 4'h0; iss_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_count", 64'(count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_iss_valid", 64'(iss_valid), 64'(0));
    check("rst_iss_uop", 64'(iss_uop), 64'(0));
    check("rst_iss_tags", 64'({iss_rs1_tag, iss_rs2_tag, iss_rd_tag, iss_lsu}), 64'(0));

    // 1: single ready ADD, visible next cycle, issues
    iss_ready = 1'b1;
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'd1);
    sb.push_back({ALU_ADD, 4'd1});
    tick();
    check("t1_count1", 64'(count), 64'(1));
    check("t1_iss_valid", 64'(iss_valid), 64'(1));
    check("t1_alu_op", 64'(iss_uop.alu_op), 64'(ALU_ADD));
    tick();
    check("t1_count0", 64'(count), 64'(0));
    check("t1_iss_idle", 64'(iss_valid), 64'(0));

    // 2: younger ready uop bypasses older waiting one; CDB wakes the older
    iss_ready = 1'b0;
    drive(ALU_SUB, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 4'd1, 1'b1, 4'd2); tick();
    drive(ALU_XOR, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd1, 1'b1, 4'd4); tick();
    check("t2_count2", 64'(count), 64'(2));
    check("t2_sel_young", 64'(iss_rd_tag), 64'(4));
    sb.push_back({ALU_XOR, 4'd4});
    iss_ready = 1'b1;
    tick();
    check("t2_waiting", 64'({count, iss_valid}), 64'({4'd1, 1'b0}));
    sb.push_back({ALU_SUB, 4'd2});
    cdb_valid = 1'b1; cdb_tag = 4'd3;
    tick();
`ifndef ISSUE_BYPASS_EN
    check("t2_woken", 64'({iss_valid, iss_rd_tag}), 64'({1'b1, 4'd2}));
    tick();
`endif
    check("t2_count0", 64'(count), 64'(0));

    // 2b: CDB match in the enqueue cycle is captured; rs2 ignored (alu_src=1)
    drive(ALU_AND, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 4'd9, 1'b0, 4'd5);
    cdb_valid = 1'b1; cdb_tag = 4'd7;
    sb.push_back({ALU_AND, 4'd5});
    tick();
    check("t2b_capture", 64'({iss_valid, iss_rd_tag}), 64'({1'b1, 4'd5}));
    tick();
    check("t2b_count0", 64'(count), 64'(0));

    // 3: LW waits, SW held behind it, ADDI issues meanwhile
    iss_ready = 1'b0;
    drive(ALU_ADD, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 4'd0, 1'b0, 4'd8); tick();
    drive(ALU_ADD, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd9); tick();
    drive(ALU_ADD, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 4'd5, 1'b0, 4'd10); tick();
    check("t3_count3", 64'(count), 64'(3));
    check("t3_addi_first", 64'({iss_valid, iss_rd_tag, iss_lsu}), 64'({1'b1, 4'd10, 1'b0}));
    sb.push_back({ALU_ADD, 4'd10});
    iss_ready = 1'b1;
    tick();
    check("t3_sw_held", 64'({count, iss_valid}), 64'({4'd2, 1'b0}));
    sb.push_back({ALU_ADD, 4'd8});
    sb.push_back({ALU_ADD, 4'd9});
    cdb_valid = 1'b1; cdb_tag = 4'd6;
    tick();
`ifndef ISSUE_BYPASS_EN
    check("t3_lw_ready", 64'({iss_rd_tag, iss_lsu}), 64'({4'd8, 1'b1}));
`endif
    drain(6);
    check("t3_count0", 64'(count), 64'(0));

    // 3b: store needs rs2 even with alu_src=1
    drive(ALU_ADD, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 4'd13, 1'b0, 4'd11); tick();
    check("t3b_st_wait", 64'(iss_valid), 64'(0));
    sb.push_back({ALU_ADD, 4'd11});
    cdb_valid = 1'b1; cdb_tag = 4'd13;
    tick();
    drain(4);

    // 4: fill to DEPTH, full queue stalls enqueue even while issuing
    iss_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op_v;
      op_v = 3'(i % 5);
      drive(op_v, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'(i));
      sb.push_back({op_v, 4'(i)});
      tick();
    end
    check("t4_full_count", 64'(count), 64'(8));
    check("t4_full_ready", 64'(in_ready), 64'(0));
    iss_ready = 1'b1;
    drive(ALU_SRA, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'd15);
    tick();
    check("t4_after_fire", 64'({count, in_ready}), 64'({4'd7, 1'b1}));
    drain(10);
    check("t4_count0", 64'(count), 64'(0));

    // 5: enqueue + issue of entry 1 at count 3
    iss_ready = 1'b0;
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 4'd2, 1'b1, 4'd1); tick();
    drive(ALU_SUB, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'd2); tick();
    drive(ALU_XOR, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 4'd2, 1'b1, 4'd3); tick();
    check("t5_sel_mid", 64'({count, iss_rd_tag}), 64'({4'd3, 4'd2}));
    sb.push_back({ALU_SUB, 4'd2});
    iss_ready = 1'b1;
    drive(ALU_AND, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'd4);
    tick();
    check("t5_count_same", 64'({count, iss_rd_tag}), 64'({4'd3, 4'd4}));
    sb.push_back({ALU_AND, 4'd4});
    tick();
    check("t5_rest_wait", 64'({count, iss_valid}), 64'({4'd2, 1'b0}));
    iss_ready = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd12; tick();
    cdb_valid = 1'b1; cdb_tag = 4'd11; tick();
    check("t5_oldest_first", 64'(iss_rd_tag), 64'(1));
    sb.push_back({ALU_ADD, 4'd1});
    sb.push_back({ALU_XOR, 4'd3});
    iss_ready = 1'b1;
    drain(4);
    check("t5_count0", 64'(count), 64'(0));

    // 6: flush with enqueue pending, then async reset mid-operation
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'(i + 1));
      tick();
    end
    check("t6_count5", 64'(count), 64'(5));
    flush = 1'b1;
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'd14);
    tick();
    check("t6_flushed", 64'({count, iss_valid, in_ready}), 64'({4'd0, 1'b0, 1'b1}));
    for (int i = 0; i < 3; i++) begin
      drive(ALU_XOR, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'(i + 1));
      tick();
    end
    check("t6_count3", 64'(count), 64'(3));
    iss_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_rst", 64'({count, iss_valid, iss_rd_tag}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_after_rst", 64'({count, iss_valid}), 64'(0));

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
